// File: rtl/data_sram_resp.sv
// Fixed-latency SRAM responder for a CPU memory stage: accepts one request at a
// time, answers with a one-cycle data_ok pulse LATENCY cycles after the handshake.
module data_sram_resp #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [2:0] CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    stateT                 stateReg, stateNext;
    logic [2:0]            cntReg, cntNext;

    logic                  holdWr;
    logic [3:0]            holdStrb;
    logic [DEPTH_LOG2-1:0] holdIdx;
    logic                  holdErr;
    logic [31:0]           holdWdata;

    logic                  handshake;
    logic [DEPTH_LOG2-1:0] reqIdx;
    logic                  reqErr;
    logic                  memWe;
    logic [DEPTH_LOG2-1:0] rdAddr;
    logic [31:0]           readWord;
    logic                  unusedAddrBits;

    assign reqIdx         = addr[DEPTH_LOG2+1:2];
    assign reqErr         = |addr[31:DEPTH_LOG2+2];
    assign unusedAddrBits = ^addr[1:0];

    assign addr_ok   = (stateReg != WAIT);
    assign handshake = req && addr_ok;
    assign data_ok   = (stateReg == RESP);

    // The pending write commits on the edge that ends its RESP cycle.
    assign memWe = data_ok && holdWr && !holdErr;

    // A LATENCY=1 request enters RESP straight from the handshake edge, before
    // the holding registers are loaded, so the read address comes from the bus.
    assign rdAddr = handshake ? reqIdx : holdIdx;

    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        unique case (stateReg)
            IDLE, RESP: begin
                if (handshake) begin
                    if (LATENCY == 1) begin
                        stateNext = RESP;
                    end else begin
                        stateNext = WAIT;
                        cntNext   = CNT_LOAD;
                    end
                end else begin
                    stateNext = IDLE;
                end
            end
            WAIT: begin
                if (cntReg == 3'd0) begin
                    stateNext = RESP;
                end else begin
                    cntNext = cntReg - 3'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg  <= IDLE;
            cntReg    <= 3'd0;
            holdWr    <= 1'b0;
            holdStrb  <= 4'd0;
            holdIdx   <= '0;
            holdErr   <= 1'b0;
            holdWdata <= 32'd0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
            if (handshake) begin
                holdWr    <= wr;
                holdStrb  <= wstrb;
                holdIdx   <= reqIdx;
                holdErr   <= reqErr;
                holdWdata <= wdata;
            end
        end
    end

    // One byte-wide array per lane so each strobe maps to its own write enable.
    // A write committing on the same edge as the read to the same word is
    // forwarded, giving read-after-write in the RESP cycle of the write.
    for (genvar gi = 0; gi < 4; gi++) begin : gLane
        logic [7:0] laneMem [DEPTH];
        logic [7:0] laneQ;
        logic [7:0] fwdByte;
        logic       fwdHit;

        always_ff @(posedge clk) begin
            if (memWe && holdStrb[gi]) begin
                laneMem[holdIdx] <= holdWdata[8*gi +: 8];
            end
            laneQ   <= laneMem[rdAddr];
            fwdHit  <= memWe && holdStrb[gi] && (rdAddr == holdIdx);
            fwdByte <= holdWdata[8*gi +: 8];
        end

        assign readWord[8*gi +: 8] = fwdHit ? fwdByte : laneQ;
    end

    assign rdata = (data_ok && !holdWr && !holdErr) ? readWord : 32'd0;
    assign err   = data_ok && holdErr;

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of storage depth in 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from request handshake to data_ok; legal range 1..7.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  CPU memory-stage request valid.
REQ-006 SHALL have port wr  input  1  1 = write, 0 = read.
REQ-007 SHALL have port wstrb  input  4  byte write enables; bit i covers wdata[8i+7:8i].
REQ-008 SHALL have port addr  input  32  byte address; addr[1:0] ignored.
REQ-009 SHALL have port wdata  input  32  write data.
REQ-010 SHALL have port addr_ok  output  1  request accepted this cycle if req is also 1.
REQ-011 SHALL have port data_ok  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rdata  output  32  read data, valid while data_ok = 1 for a read.
REQ-013 SHALL have port err  output  1  out-of-range flag, valid while data_ok = 1.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-015 SHALL drive addr_ok = 1 in IDLE and RESP, and 0 in WAIT.
REQ-016 SHALL treat a cycle with req = 1 and addr_ok = 1 as a handshake that captures wr, wstrb, addr and wdata into holding registers.
REQ-017 SHALL assert data_ok exactly LATENCY cycles after the handshake cycle, for exactly one cycle (RESP).
REQ-018 SHALL transition on handshake from IDLE or RESP to RESP when LATENCY = 1, and otherwise to WAIT with a 3-bit down-counter loaded with LATENCY-2.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and go to RESP when it reads 0.
REQ-020 SHALL go from RESP to IDLE when no handshake occurs in that cycle.
REQ-021 SHALL accept a back-to-back request in the RESP cycle, so the minimum request spacing is LATENCY cycles.
REQ-022 SHALL compute word index = addr[DEPTH_LOG2+1:2] and flag out-of-range when addr[31:DEPTH_LOG2+2] is nonzero.
REQ-023 SHALL, for an in-range read, drive rdata in RESP with the stored word as of that cycle.
REQ-024 SHALL, for an in-range write, update only the enabled bytes on the clock edge that ends the RESP cycle; wstrb = 0000 writes nothing.
REQ-025 SHALL, for an out-of-range access, drive err = 1 and rdata = 0, and leave storage unchanged.
REQ-026 SHALL hold rdata = 0 and err = 0 whenever data_ok = 0.
REQ-027 SHALL ignore req while addr_ok = 0; inputs changing in WAIT have no effect on the pending request.
REQ-028 SHALL let a read accepted in the RESP cycle of a write to the same word return the newly written data.

Reset
REQ-029 SHALL, while rst = 0, force state IDLE, counter 0, holding registers 0, data_ok 0, rdata 0, err 0; addr_ok is 1 once rst = 1.
REQ-030 SHALL discard any pending request when rst asserts mid-operation; no write is committed and no data_ok is produced.
REQ-031 SHALL NOT reset storage contents.

Verification
REQ-032 SHALL cover this case with LATENCY = 2: write 0xDEADBEEF to 0x10 with wstrb 1111, then read 0x10 -> data_ok 2 cycles after each handshake, and the read returns 0xDEADBEEF with err = 0.
REQ-033 SHALL cover this case: write 0x11223344 to 0x20 with wstrb 1111, then write 0xAABBCCDD to 0x20 with wstrb 0101, then read 0x20 -> 0x11BB33DD.
REQ-034 SHALL cover this case with DEPTH_LOG2 = 10: read at 0x00001000 -> err = 1, rdata = 0; a write at the same address leaves word 0 unchanged.
REQ-035 SHALL cover this case with LATENCY = 3: req held 1 continuously with 4 reads -> addr_ok pattern 1,0,0,1,0,0,1..., and exactly 4 data_ok pulses with no lost or duplicated response.
REQ-036 SHALL cover this case: write 0x5 to 0x40 accepted, then rst pulsed low during WAIT, then read 0x40 -> returns the prior contents (not 0x5), with no data_ok during or after reset for the aborted write.
REQ-037 SHALL cover this case with LATENCY = 1: write 0x7 to 0x8, then read 0x8 accepted in the RESP cycle -> the read data_ok returns 0x7 in the next cycle.
